// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit
// Multi-cycle shift/rotate unit (SHR, SHRA, SHL, ROR, ROL). Moves at most
// STEP bit positions per RUN cycle and reports completion with a done pulse.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   STEP   maximum bit positions moved per RUN cycle (1..WIDTH)
//
// Ports:
//   i_clk     system clock, rising edge
//   i_reset   synchronous active-low reset
//   i_start   request, sampled in IDLE or DONE only
//   i_op      000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
//   i_a       value to shift
//   i_b       shift amount
//   o_busy    high while in RUN
//   o_done    one-cycle completion pulse
//   o_err     pulses with o_done when the accepted op was illegal
//   o_result  final value, held until the next accepted start
//
// Build option:
//   SHIFT_SATURATE_EN  clamps the SHR/SHRA/SHL amount to WIDTH when b >= WIDTH;
//                      when undefined, every op uses b[AMT_W-1:0].

module shift_rotate_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned AMT_W = $clog2(WIDTH);
  // One extra bit so the remaining count can hold WIDTH itself.
  localparam int unsigned CNT_W = AMT_W + 1;

  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_work;
  logic [CNT_W-1:0]   r_rem;

  logic               w_illegal;
  logic [CNT_W-1:0]   w_n;
  logic [CNT_W-1:0]   w_k;
  logic [CNT_W-1:0]   w_kc;
  logic [CNT_W-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_step;

  assign w_illegal = (i_op > OP_ROL);

  // Effective shift amount for the request on the inputs.
`ifdef SHIFT_SATURATE_EN
  logic w_b_big;
  assign w_b_big = (|i_b[WIDTH-1:AMT_W]) || ({1'b0, i_b[AMT_W-1:0]} >= WIDTH_C);

  always_comb begin
    w_n = {1'b0, i_b[AMT_W-1:0]};
    if (((i_op == OP_SHR) || (i_op == OP_SHRA) || (i_op == OP_SHL)) && w_b_big) begin
      w_n = WIDTH_C;
    end
    if (w_illegal) begin
      w_n = '0;
    end
  end
`else
  logic w_unused_b_hi;
  assign w_unused_b_hi = ^i_b[WIDTH-1:AMT_W];

  always_comb begin
    w_n = {1'b0, i_b[AMT_W-1:0]};
    if (w_illegal) begin
      w_n = '0;
    end
  end
`endif

  // One RUN step: move by k = min(STEP, rem). k never exceeds WIDTH,
  // so the complementary rotate distance WIDTH-k cannot underflow.
  always_comb begin
    w_k       = (r_rem < STEP_C) ? r_rem : STEP_C;
    w_kc      = WIDTH_C - w_k;
    w_rem_nxt = r_rem - w_k;
    w_step    = r_work;
    case (r_op)
      OP_SHR:  w_step = r_work >> w_k;
      OP_SHRA: w_step = $unsigned($signed(r_work) >>> w_k);
      OP_SHL:  w_step = r_work << w_k;
      OP_ROR:  w_step = (r_work >> w_k) | (r_work << w_kc);
      OP_ROL:  w_step = (r_work << w_k) | (r_work >> w_kc);
      default: w_step = r_work;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_work   <= '0;
      r_rem    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_result <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_op   <= i_op;
            r_work <= i_a;
            r_rem  <= w_n;
            if (w_n == '0) begin
              // Zero amount or illegal op completes without a RUN phase.
              r_state  <= ST_DONE;
              o_result <= i_a;
              o_done   <= 1'b1;
              o_err    <= w_illegal;
            end else begin
              r_state <= ST_RUN;
              o_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_work <= w_step;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_state  <= ST_DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_result <= w_step;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Testbench for shift_rotate_unit: one instance with STEP=1 (index 0) and one
// with STEP=4 (index 1), both WIDTH=32. Expected results are kept in a
// scoreboard queue and compared when each done pulse appears.
`timescale 1ns/1ps

module tb_shift_rotate_unit;

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         st0, st1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         busy0, busy1, done0, done1, err0, err1;
  logic [W-1:0] res0, res1;

  int checks   = 0;
  int failures = 0;

  shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_step1 (
    .i_clk(clk), .i_reset(rst_n), .i_start(st0), .i_op(op0), .i_a(a0), .i_b(b0),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .o_result(res0)
  );

  shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_step4 (
    .i_clk(clk), .i_reset(rst_n), .i_start(st1), .i_op(op1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_result(res1)
  );

  typedef struct {
    int         d;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic       err;
  } vec_t;

  typedef struct {
    int          d;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          busy_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int eff_n(input logic [2:0] op, input logic [31:0] b);
    if (op > OP_ROL) return 0;
`ifdef SHIFT_SATURATE_EN
    if (op <= OP_SHL && b >= 32) return 32;
`endif
    return int'(b[4:0]);
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int n = eff_n(op, b);
    int m = n % 32;
    case (op)
      OP_SHR:  return a >> n;
      OP_SHRA: return $unsigned($signed(a) >>> n);
      OP_SHL:  return a << n;
      OP_ROR:  return (m == 0) ? a : ((a >> m) | (a << (32 - m)));
      OP_ROL:  return (m == 0) ? a : ((a << m) | (a >> (32 - m)));
      default: return a;
    endcase
  endfunction

  task automatic drive(input int d, input logic s, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    if (d == 0) begin
      st0 = s; op0 = o; a0 = x; b0 = y;
    end else begin
      st1 = s; op1 = o; a1 = x; b1 = y;
    end
  endtask

  task automatic peek(input int d, output logic bz, output logic dn, output logic er,
                      output logic [31:0] rs);
    if (d == 0) begin
      bz = busy0; dn = done0; er = err0; rs = res0;
    end else begin
      bz = busy1; dn = done1; er = err1; rs = res1;
    end
  endtask

  // Drive a request (start high until the next edge) and record its expectation.
  task automatic launch(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eres, input logic eerr);
    exp_t e;
    int n = eff_n(op, b);
    int l = (n + step_of(d) - 1) / step_of(d);
    drive(d, 1'b1, op, a, b);
    e.d        = d;
    e.res      = eres;
    e.err      = eerr;
    e.lat      = (n == 0) ? 1 : l + 1;
    e.busy_cyc = (n == 0) ? 0 : l;
    sb.push_back(e);
  endtask

  // Wait for done on instance d; returns on the negedge where done is seen.
  // poke > 0 raises start with junk operands in that cycle (must be ignored).
  task automatic await_done(input int d, input int poke);
    exp_t        e;
    logic        bz, dn, er;
    logic [31:0] rs;
    int          c = 0;
    int          busy_cnt = 0;
    bit          overlap = 0;
    bit          seen = 0;
    @(posedge clk);
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) drive(d, 1'b0, 3'($urandom), $urandom, $urandom);
      if (poke > 0 && c == poke) drive(d, 1'b1, OP_SHR, 32'hFFFF_FFFF, 32'h1);
      if (poke > 0 && c == poke + 1) drive(d, 1'b0, OP_SHL, 32'h0, 32'h0);
      peek(d, bz, dn, er, rs);
      if (bz) busy_cnt++;
      if (bz && dn) overlap = 1;
      if (dn) seen = 1;
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk("sb_instance", 32'(d), 32'(e.d));
      if (!seen) begin
        checks++; failures++;
        $display("FAIL done_timeout actual=no_done required=done_within_%0d_cycles", e.lat);
      end else begin
        chk("result", rs, e.res);
        chk("err", {31'b0, er}, {31'b0, e.err});
        chk("latency", 32'(c), 32'(e.lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_cyc));
        chk("busy_done_overlap", {31'b0, overlap}, 32'h0);
      end
    end
  endtask

  // After completion, done must drop and result must hold.
  task automatic hold_check(input int d, input logic [31:0] eres);
    logic        bz, dn, er;
    logic [31:0] rs;
    repeat (2) @(negedge clk);
    peek(d, bz, dn, er, rs);
    chk("idle_done_low", {31'b0, dn}, 32'h0);
    chk("idle_result_hold", rs, eres);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bz, dn, er;
    logic [31:0] rs;
    bit          stray_done;

    tv[0]  = '{0, OP_SHRA, 32'hF000_5022, 32'h8,  32'hFFF0_0050, 1'b0};
    tv[1]  = '{0, OP_SHR,  32'hF000_5022, 32'h8,  32'h00F0_0050, 1'b0};
    tv[2]  = '{1, OP_ROR,  32'h0000_0028, 32'h3,  32'h0000_0005, 1'b0};
    tv[3]  = '{1, OP_SHL,  32'h0000_0001, 32'h0,  32'h0000_0001, 1'b0};
`ifdef SHIFT_SATURATE_EN
    tv[4]  = '{0, OP_SHL,  32'h0000_0001, 32'h28, 32'h0000_0000, 1'b0};
    tv[11] = '{1, OP_SHR,  32'h8000_0000, 32'h3F, 32'h0000_0000, 1'b0};
`else
    tv[4]  = '{0, OP_SHL,  32'h0000_0001, 32'h28, 32'h0000_0100, 1'b0};
    tv[11] = '{1, OP_SHR,  32'h8000_0000, 32'h3F, 32'h0000_0001, 1'b0};
`endif
    tv[5]  = '{0, 3'b110,  32'h1234_5678, 32'h5,  32'h1234_5678, 1'b1};
    tv[6]  = '{1, OP_SHRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0};
    tv[7]  = '{1, OP_ROL,  32'h1234_5678, 32'h4,  32'h2345_6781, 1'b0};
    tv[8]  = '{1, OP_SHL,  32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 1'b0};
    tv[9]  = '{0, OP_ROR,  32'h0000_0001, 32'h1,  32'h8000_0000, 1'b0};
    tv[10] = '{1, 3'b111,  32'hA5A5_A5A5, 32'h3,  32'hA5A5_A5A5, 1'b1};
    tv[12] = '{1, OP_ROR,  32'h8765_4321, 32'h24, 32'h1876_5432, 1'b0};
    tv[13] = '{0, OP_SHRA, 32'h7FFF_FFFF, 32'h3,  32'h0FFF_FFFF, 1'b0};

    // Reset state of both instances.
    rst_n = 1'b0;
    drive(0, 1'b0, OP_SHR, 32'h0, 32'h0);
    drive(1, 1'b0, OP_SHR, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      peek(d, bz, dn, er, rs);
      chk("reset_busy", {31'b0, bz}, 32'h0);
      chk("reset_done", {31'b0, dn}, 32'h0);
      chk("reset_err", {31'b0, er}, 32'h0);
      chk("reset_result", rs, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      launch(tv[i].d, tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].err);
      await_done(tv[i].d, 0);
      hold_check(tv[i].d, tv[i].res);
    end

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk);
    launch(0, OP_SHR, 32'hF000_5022, 32'h8, 32'h00F0_0050, 1'b0);
    await_done(0, 0);
    launch(0, OP_ROL, 32'h8000_0001, 32'h4, 32'h0000_0018, 1'b0);
    await_done(0, 0);
    hold_check(0, 32'h0000_0018);

    // Back-to-back on STEP=4: rotate, zero-amount shift, illegal op.
    launch(1, OP_ROR, 32'h0000_0028, 32'h3, 32'h0000_0005, 1'b0);
    await_done(1, 0);
    launch(1, OP_SHL, 32'h0000_0001, 32'h0, 32'h0000_0001, 1'b0);
    await_done(1, 0);
    launch(1, 3'b101, 32'hDEAD_BEEF, 32'h7, 32'hDEAD_BEEF, 1'b1);
    await_done(1, 0);
    hold_check(1, 32'hDEAD_BEEF);

    // Start during RUN must be ignored.
    launch(0, OP_SHL, 32'h0000_0001, 32'd10, 32'h0000_0400, 1'b0);
    await_done(0, 3);
    hold_check(0, 32'h0000_0400);

    // Reset in the middle of a RUN discards the op.
    drive(0, 1'b1, OP_SHRA, 32'hF000_5022, 32'd16);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, OP_SHR, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    peek(0, bz, dn, er, rs);
    chk("pre_reset_busy", {31'b0, bz}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    peek(0, bz, dn, er, rs);
    chk("midrun_reset_busy", {31'b0, bz}, 32'h0);
    chk("midrun_reset_done", {31'b0, dn}, 32'h0);
    chk("midrun_reset_err", {31'b0, er}, 32'h0);
    chk("midrun_reset_result", rs, 32'h0);
    rst_n = 1'b1;
    stray_done = 0;
    repeat (40) begin
      @(negedge clk);
      peek(0, bz, dn, er, rs);
      if (dn || bz) stray_done = 1;
    end
    chk("no_done_after_reset", {31'b0, stray_done}, 32'h0);
    launch(0, OP_SHRA, 32'hF000_5022, 32'd16, 32'hFFFF_F000, 1'b0);
    await_done(0, 0);

    // Randomised operands checked against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          d = i % 2;
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 40));
      @(negedge clk);
      launch(d, rop, ra, rb, model(rop, ra, rb), rop > OP_ROL);
      await_done(d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
